// File: rtl/bit_reg_hex_display.sv
// -----------------------------------------------------------------------------
// bit_reg_hex_display
//
// Holds an 8-bit value that is built one bit at a time. Each write picks a bit
// by index and sets or clears it. The value is shown as two hex digits on a
// two-digit, time-multiplexed, common-anode 7-segment display.
//
// Parameters
//   REFRESH_CYCLES : clk cycles each digit stays lit before the display
//                    switches to the other digit (>= 1).
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   reset      : synchronous reset, active-low
//   bit_index  : bit position (0..7) written when valid_in is high
//   bit_value  : value written into data[bit_index]
//   valid_in   : write strobe, accepted on every rising edge it is high
//   display    : segment cathodes {g,f,e,d,c,b,a}, active-low
//   seg        : digit anodes, active-low; seg[0] = low nibble, seg[1] = high
// -----------------------------------------------------------------------------
module bit_reg_hex_display #(
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] bit_index,
    input  logic       bit_value,
    input  logic       valid_in,
    output logic [6:0] display,
    output logic [1:0] seg
);

    // A counter of at least one bit keeps REFRESH_CYCLES=1 legal.
    localparam int CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_CYCLES - 1);

    logic [7:0]       data_reg;
    logic [7:0]       data_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             sel_reg;
    logic             sel_next;
    logic [3:0]       nibble;

    // Each bit gets its own write decode. When valid_in is low, bit_index may be X.
    // The AND with valid_in keeps that X out of the enable path.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign data_next[gi] = (valid_in && (bit_index == 3'(gi)))
                                   ? bit_value : data_reg[gi];
        end
    endgenerate

    // The refresh counter wraps at CNT_MAX. The digit select toggles on the same edge.
    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        sel_next = sel_reg;
        if (cnt_reg == CNT_MAX) begin
            cnt_next = '0;
            sel_next = ~sel_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_reg <= 8'h00;
            cnt_reg  <= '0;
            sel_reg  <= 1'b0;
        end else begin
            data_reg <= data_next;
            cnt_reg  <= cnt_next;
            sel_reg  <= sel_next;
        end
    end

    // Output path is combinational from the data register and the select flop.
    // A write is therefore visible right after the edge that performs it.
    assign seg    = sel_reg ? 2'b01 : 2'b10;
    assign nibble = sel_reg ? data_reg[7:4] : data_reg[3:0];

    always_comb begin
        display = 7'b1111111;
        case (nibble)
            4'h0: display = 7'b1000000;
            4'h1: display = 7'b1111001;
            4'h2: display = 7'b0100100;
            4'h3: display = 7'b0110000;
            4'h4: display = 7'b0011001;
            4'h5: display = 7'b0010010;
            4'h6: display = 7'b0000010;
            4'h7: display = 7'b1111000;
            4'h8: display = 7'b0000000;
            4'h9: display = 7'b0010000;
            4'hA: display = 7'b0001000;
            4'hB: display = 7'b0000011;
            4'hC: display = 7'b1000110;
            4'hD: display = 7'b0100001;
            4'hE: display = 7'b0000110;
            4'hF: display = 7'b0001110;
            default: display = 7'b1111111;
        endcase
    end

endmodule

// File: tb/tb_bit_reg_hex_display.sv
// -----------------------------------------------------------------------------
// tb_bit_reg_hex_display
//
// Directed and random stimulus for bit_reg_hex_display with REFRESH_CYCLES=4.
// The reference model keeps the byte value and the number of clock edges since
// the last reset. The lit digit is (edges / 4) mod 2.
// -----------------------------------------------------------------------------
module tb_bit_reg_hex_display;

    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] bit_index;
    logic       bit_value;
    logic       valid_in;
    logic [6:0] display;
    logic [1:0] seg;

    bit_reg_hex_display #(.REFRESH_CYCLES(RC)) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_index (bit_index),
        .bit_value (bit_value),
        .valid_in  (valid_in),
        .display   (display),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_data;
    int         m_edges;
    logic [6:0] hex_tbl [16];

    function automatic logic m_sel();
        return ((m_edges / RC) % 2) == 1;
    endfunction

    task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply one clock edge with the given inputs, update the model, and compare.
    task automatic step(input string tag, input logic rst_n, input logic vld,
                        input logic [2:0] idx, input logic val);
        logic [6:0] exp_disp;
        logic [1:0] exp_seg;
        @(negedge clk);
        reset     = rst_n;
        valid_in  = vld;
        bit_index = idx;
        bit_value = val;
        @(posedge clk);
        if (!rst_n) begin
            m_data  = 8'h00;
            m_edges = 0;
        end else begin
            if (vld) m_data[idx] = val;
            m_edges++;
        end
        #1;
        exp_seg  = m_sel() ? 2'b01 : 2'b10;
        exp_disp = m_sel() ? hex_tbl[m_data[7:4]] : hex_tbl[m_data[3:0]];
        check2(tag, seg, exp_seg);
        check7(tag, display, exp_disp);
        $display("step %-8s rst=%b vld=%b idx=%0d val=%b | data=%h seg=%b display=%b",
                 tag, rst_n, vld, idx, val, m_data, seg, display);
    endtask

    initial begin
        hex_tbl[0]  = 7'b1000000; hex_tbl[1]  = 7'b1111001;
        hex_tbl[2]  = 7'b0100100; hex_tbl[3]  = 7'b0110000;
        hex_tbl[4]  = 7'b0011001; hex_tbl[5]  = 7'b0010010;
        hex_tbl[6]  = 7'b0000010; hex_tbl[7]  = 7'b1111000;
        hex_tbl[8]  = 7'b0000000; hex_tbl[9]  = 7'b0010000;
        hex_tbl[10] = 7'b0001000; hex_tbl[11] = 7'b0000011;
        hex_tbl[12] = 7'b1000110; hex_tbl[13] = 7'b0100001;
        hex_tbl[14] = 7'b0000110; hex_tbl[15] = 7'b0001110;
        m_data    = 8'h00;
        m_edges   = 0;
        reset     = 1'b0;
        valid_in  = 1'b0;
        bit_index = 3'd0;
        bit_value = 1'b0;

        // Reset: low digit "0"
        step("reset", 1'b0, 1'b0, 3'd0, 1'b0);
        check2("rst_seg", seg, 2'b10);
        check7("rst_disp", display, 7'b1000000);
        for (int i = 0; i < 2 * RC; i++) step("zero", 1'b1, 1'b0, 3'd0, 1'b0);

        // Sequential writes, five cycles each: value becomes 0x05
        for (int i = 0; i < 5; i++) step("w0", 1'b1, 1'b1, 3'd0, 1'b1);
        for (int i = 0; i < 5; i++) step("w1", 1'b1, 1'b1, 3'd1, 1'b0);
        for (int i = 0; i < 5; i++) step("w2", 1'b1, 1'b1, 3'd2, 1'b1);
        for (int i = 0; i < 5; i++) step("w3", 1'b1, 1'b1, 3'd3, 1'b0);
        for (int i = 0; i < 2 * RC; i++) step("mux05", 1'b1, 1'b0, 3'd0, 1'b0);

        // High-nibble write: 0x85, then back to 0x05
        for (int i = 0; i < 2 * RC; i++) step("w7set", 1'b1, 1'b1, 3'd7, 1'b1);
        for (int i = 0; i < 2 * RC; i++) step("w7clr", 1'b1, 1'b1, 3'd7, 1'b0);

        // valid_in low with random index/value: data must hold
        for (int i = 0; i < 10; i++)
            step("idle", 1'b1, 1'b0, 3'($urandom_range(7)), 1'($urandom_range(1)));

        // Fill to 0xFF, then wait for the high digit to be lit (bounded)
        for (int b = 0; b < 8; b++) step("fill", 1'b1, 1'b1, 3'(b), 1'b1);
        for (int i = 0; i < 2 * RC && !m_sel(); i++) step("waithi", 1'b1, 1'b0, 3'd0, 1'b0);
        check2("hi_lit", seg, 2'b01);
        check7("hi_F", display, 7'b0001110);

        // Reset mid-stream with a simultaneous write: the write is ignored
        step("midrst", 1'b0, 1'b1, 3'd0, 1'b1);
        check2("midrst_seg", seg, 2'b10);
        check7("midrst_disp", display, 7'b1000000);
        for (int i = 0; i < 2 * RC; i++) step("postrst", 1'b1, 1'b0, 3'd0, 1'b0);

        // Random traffic, including an occasional reset
        for (int i = 0; i < 120; i++)
            step("rand", ($urandom_range(29) != 0), 1'($urandom_range(1)),
                 3'($urandom_range(7)), 1'($urandom_range(1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
